// File: rtl/axis_pkt_pkg.sv
// axis_pkt_pkg: shared FSM state type and byte width for the AXI-Stream packet buffer.
package axis_pkt_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, RECV, DONE, DROP} state_t;
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, byte-enabled write port, registered read port (read-old-data on collision).
// Ports: clk, rst_n (clears only the read register), we_i/be_i/waddr_i/wdata_i write port,
//        raddr_i/rdata_o read port with one cycle latency.
module sdp_ram
  import axis_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 128,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int KEEP_WIDTH = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [KEEP_WIDTH-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  // Storage is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk)
    for (int i = 0; i < KEEP_WIDTH; i++)
      if (we_i && be_i[i]) mem_q[waddr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
  // Non-blocking read of the array returns the pre-write word on a same-address collision.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_o <= '0;
    else rdata_o <= mem_q[raddr_i];
endmodule

// File: rtl/axis_slave_pktmem.sv
// axis_slave_pktmem: AXI-Stream slave that stores one packet into a buffer until the consumer releases it.
// Ports: s_axis_* stream slave (aclk, active-low async aresetn, tdata/tstrb/tkeep/tvalid/tready/tlast),
//        rd_addr/rd_data registered buffer read, buf_release frees a held packet,
//        pkt_done/pkt_len describe the held packet, err_overflow is sticky until reset.
// Build option: AXIS_SLAVE_PKTMEM_STRB_EN enables per-byte writes gated by tstrb & tkeep.
module axis_slave_pktmem
  import axis_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 128,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int KEEP_WIDTH = DATA_WIDTH / BYTE_W
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tstrb,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  buf_release,
  output logic                  pkt_done,
  output logic [ADDR_WIDTH:0]   pkt_len,
  output logic                  err_overflow
);
  state_t                state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  acc, full, we;
  logic [KEEP_WIDTH-1:0] be;
  assign acc  = s_axis_tvalid && s_axis_tready;
  assign full = cnt_q == (ADDR_WIDTH+1)'(DEPTH);
  assign we   = acc && (state_q == IDLE || (state_q == RECV && !full));
`ifdef AXIS_SLAVE_PKTMEM_STRB_EN
  assign be = s_axis_tstrb & s_axis_tkeep;
`else
  logic unused_strb;
  assign be = '1;
  assign unused_strb = ^{s_axis_tstrb, s_axis_tkeep};
`endif
  // cnt_q is both the beat count and the next write address; it is 0 whenever the FSM sits in IDLE.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn)
    if (!s_axis_aresetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      s_axis_tready <= 1'b0;
      pkt_done      <= 1'b0;
      pkt_len       <= '0;
      err_overflow  <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      case (state_q)
        IDLE: if (acc) begin
          cnt_q   <= (ADDR_WIDTH+1)'(1);
          state_q <= s_axis_tlast ? DONE : RECV;
          if (s_axis_tlast) begin
            pkt_done      <= 1'b1;
            pkt_len       <= (ADDR_WIDTH+1)'(1);
            s_axis_tready <= 1'b0;
          end
        end
        RECV: if (acc && full) begin
          // An overflowing beat that is itself the last one needs no drain phase.
          state_q      <= s_axis_tlast ? IDLE : DROP;
          cnt_q        <= '0;
          err_overflow <= 1'b1;
        end else if (acc) begin
          cnt_q <= cnt_q + 1'b1;
          if (s_axis_tlast) begin
            state_q       <= DONE;
            pkt_done      <= 1'b1;
            pkt_len       <= cnt_q + 1'b1;
            s_axis_tready <= 1'b0;
          end
        end
        DROP: if (acc && s_axis_tlast) state_q <= IDLE;
        DONE: if (buf_release) begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          pkt_done <= 1'b0;
        end else s_axis_tready <= 1'b0;
      endcase
    end
  sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk    (s_axis_aclk),
    .rst_n  (s_axis_aresetn),
    .we_i   (we),
    .be_i   (be),
    .waddr_i(cnt_q[ADDR_WIDTH-1:0]),
    .wdata_i(s_axis_tdata),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );
endmodule

// File: tb/tb_axis_slave_pktmem.sv
// tb_axis_slave_pktmem: directed self-checking bench for axis_slave_pktmem (DATA_WIDTH=32, DEPTH=128).
module tb_axis_slave_pktmem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tdata = '0;
  logic [3:0]  tstrb = '1;
  logic [3:0]  tkeep = '1;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        tlast = 1'b0;
  logic [6:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        buf_release = 1'b0;
  logic        pkt_done;
  logic [7:0]  pkt_len;
  logic        err_overflow;
  logic [15:0] lfsr = 16'hACE1;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  axis_slave_pktmem #(.DATA_WIDTH(32), .DEPTH(128)) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tstrb  (tstrb),
    .s_axis_tkeep  (tkeep),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .buf_release   (buf_release),
    .pkt_done      (pkt_done),
    .pkt_len       (pkt_len),
    .err_overflow  (err_overflow)
  );

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [3:0] st, input logic [3:0] kp);
    int w = 0;
    @(negedge clk);
    tdata = d; tlast = last; tstrb = st; tkeep = kp; tvalid = 1'b1;
    while (!tready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!tready) begin
      n_chk++; n_fail++;
      $display("FAIL tready_timeout got %b want 1", tready);
    end
    @(posedge clk);
    #1 tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    @(negedge clk);
    rd_addr = 7'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic release_buf();
    @(negedge clk);
    buf_release = 1'b1;
    @(negedge clk);
    buf_release = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready got %b want 0", tready); end
    n_chk++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL rst_pkt_done got %b want 0", pkt_done); end
    n_chk++; if (pkt_len !== 8'd0) begin n_fail++; $display("FAIL rst_pkt_len got %0d want 0", pkt_len); end
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err_overflow); end
    n_chk++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rst_rd_data got %h want 0", rd_data); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (tready !== 1'b1) begin n_fail++; $display("FAIL rst_tready_rise got %b want 1", tready); end
  endtask

  task automatic test_stream();
    logic [31:0] d;
    for (int i = 0; i < 128; i++) begin
      for (int k = 0; k < 3 && !lfsr[0]; k++) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        @(negedge clk);
      end
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      send_beat(32'(i), i == 127, 4'hF, 4'hF);
    end
    @(negedge clk);
    n_chk++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL stream_done got %b want 1", pkt_done); end
    n_chk++; if (pkt_len !== 8'd128) begin n_fail++; $display("FAIL stream_len got %0d want 128", pkt_len); end
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL stream_err got %b want 0", err_overflow); end
    n_chk++; if (tready !== 1'b0) begin n_fail++; $display("FAIL stream_tready got %b want 0", tready); end
    for (int a = 0; a < 128; a++) begin
      rd(a, d);
      n_chk++; if (d !== 32'(a)) begin n_fail++; $display("FAIL stream_rd[%0d] got %h want %h", a, d, 32'(a)); end
    end
    release_buf();
    n_chk++; if (tready !== 1'b1) begin n_fail++; $display("FAIL release_tready got %b want 1", tready); end
    n_chk++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL release_done got %b want 0", pkt_done); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 128; i++) send_beat(32'(1000 + i), 1'b0, 4'hF, 4'hF);
    @(negedge clk);
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_err_128 got %b want 0", err_overflow); end
    n_chk++; if (tready !== 1'b1) begin n_fail++; $display("FAIL ovf_tready_128 got %b want 1", tready); end
    send_beat(32'hBAD0BAD0, 1'b0, 4'hF, 4'hF);
    @(negedge clk);
    n_chk++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_err_129 got %b want 1", err_overflow); end
    n_chk++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL ovf_done_129 got %b want 0", pkt_done); end
    n_chk++; if (tready !== 1'b1) begin n_fail++; $display("FAIL ovf_tready_drop got %b want 1", tready); end
    send_beat(32'hBAD1BAD1, 1'b1, 4'hF, 4'hF);
    @(negedge clk);
    n_chk++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL ovf_done_130 got %b want 0", pkt_done); end
    n_chk++; if (tready !== 1'b1) begin n_fail++; $display("FAIL ovf_tready_130 got %b want 1", tready); end
    rd(0, d);
    n_chk++; if (d !== 32'd1000) begin n_fail++; $display("FAIL ovf_addr0 got %h want %h", d, 32'd1000); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    send_beat(32'hDEADBEEF, 1'b1, 4'hF, 4'hF);
    repeat (3) @(negedge clk);
    n_chk++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL single_done got %b want 1", pkt_done); end
    n_chk++; if (pkt_len !== 8'd1) begin n_fail++; $display("FAIL single_len got %0d want 1", pkt_len); end
    n_chk++; if (tready !== 1'b0) begin n_fail++; $display("FAIL single_tready got %b want 0", tready); end
    n_chk++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL sticky_err got %b want 1", err_overflow); end
    rd(0, d);
    n_chk++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rd got %h want deadbeef", d); end
    release_buf();
    n_chk++; if (tready !== 1'b1) begin n_fail++; $display("FAIL single_release got %b want 1", tready); end
  endtask

  task automatic test_release_in_recv();
    send_beat(32'h11, 1'b0, 4'hF, 4'hF);
    send_beat(32'h22, 1'b0, 4'hF, 4'hF);
    @(negedge clk);
    buf_release = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (tready !== 1'b1) begin n_fail++; $display("FAIL recv_release_tready got %b want 1", tready); end
    buf_release = 1'b0;
    send_beat(32'h33, 1'b1, 4'hF, 4'hF);
    @(negedge clk);
    n_chk++; if (pkt_len !== 8'd3) begin n_fail++; $display("FAIL recv_release_len got %0d want 3", pkt_len); end
    n_chk++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL recv_release_done got %b want 1", pkt_done); end
    release_buf();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send_beat(32'h50 + 32'(i), 1'b0, 4'hF, 4'hF);
    rd_addr = 7'd1;
    repeat (2) @(negedge clk);
    n_chk++; if (rd_data !== 32'h51) begin n_fail++; $display("FAIL mid_rd got %h want 51", rd_data); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (tready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tready got %b want 0", tready); end
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %b want 0", err_overflow); end
    n_chk++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL mid_rst_rd_data got %h want 0", rd_data); end
    n_chk++; if (pkt_len !== 8'd0) begin n_fail++; $display("FAIL mid_rst_len got %0d want 0", pkt_len); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(32'h70 + 32'(i), i == 2, 4'hF, 4'hF);
    @(negedge clk);
    n_chk++; if (pkt_len !== 8'd3) begin n_fail++; $display("FAIL mid_next_len got %0d want 3", pkt_len); end
    n_chk++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL mid_next_done got %b want 1", pkt_done); end
    release_buf();
  endtask

  task automatic test_strobes();
    logic [31:0] d;
    send_beat(32'hFFFFFFFF, 1'b1, 4'hF, 4'hF);
    release_buf();
    rd_addr = 7'd0;
    send_beat(32'h12345678, 1'b1, 4'b0101, 4'b1111);
    @(negedge clk);
    n_chk++; if (rd_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL collision_old got %h want ffffffff", rd_data); end
    rd(0, d);
`ifdef AXIS_SLAVE_PKTMEM_STRB_EN
    n_chk++; if (d !== 32'hFF34FF78) begin n_fail++; $display("FAIL strb_merge got %h want ff34ff78", d); end
`else
    n_chk++; if (d !== 32'h12345678) begin n_fail++; $display("FAIL strb_ignored got %h want 12345678", d); end
`endif
    release_buf();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_single();
    test_release_in_recv();
    test_reset_mid();
    test_strobes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
